// File: rtl/ws_writeback_pkg.sv
// Shared types and constants for the 8x8 block write-back engine: FSM states,
// plane encoding, SRAM plane geometry and default base addresses.
package ws_writeback_pkg;

    typedef enum logic [2:0] {
        S_WS_IDLE,
        S_WS_LEAD_IN,
        S_WS_COMMON,
        S_WS_LEAD_OUT,
        S_WS_DONE
    } ws_state_type;

    typedef enum logic [1:0] {
        PLANE_Y       = 2'd0,
        PLANE_U       = 2'd1,
        PLANE_V       = 2'd2,
        PLANE_INVALID = 2'd3
    } ws_plane_type;

    localparam logic [17:0] Y_WORDS_PER_ROW  = 18'd160;
    localparam logic [17:0] UV_WORDS_PER_ROW = 18'd80;

    localparam logic [17:0] Y_BASE_DEFAULT     = 18'd0;
    localparam logic [17:0] U_BASE_DEFAULT     = 18'd38400;
    localparam logic [17:0] V_BASE_DEFAULT     = 18'd57600;
    localparam logic [6:0]  S_RAM_BASE_DEFAULT = 7'd64;

    // Offset of the first SRAM row of block row rb: rb*8*160 or rb*8*80, built from shifts.
    function automatic logic [17:0] block_row_offset(input logic [4:0] rb, input logic is_y);
        logic [17:0] r;
        r = {13'd0, rb};
        if (is_y)
            return (r << 10) + (r << 8);
        return (r << 9) + (r << 7);
    endfunction

endpackage

// File: rtl/ws_writeback_clip8.sv
// Converts one signed 32-bit sample to an 8-bit pixel. With WS_CLIP_EN defined
// the value saturates to 0..255, otherwise the low byte is kept.
module ws_clip8 (
    input  logic signed [31:0] value,
    output logic [7:0]         pixel
);

`ifdef WS_CLIP_EN
    always_comb begin
        if (value < 0)
            pixel = 8'd0;
        else if (value > 32'sd255)
            pixel = 8'd255;
        else
            pixel = value[7:0];
    end
`else
    logic [23:0] unused_high;
    assign unused_high = value[31:8];
    assign pixel       = value[7:0];
`endif

endmodule

// File: rtl/ws_writeback.sv
// Writes one 8x8 block of S samples from the dual-port RAM into the SRAM frame
// as packed pixel pairs. Pixel conversion saturates when WS_CLIP_EN is defined.
module ws_writeback
    import ws_writeback_pkg::*;
#(
    parameter logic [17:0] Y_BASE     = Y_BASE_DEFAULT,
    parameter logic [17:0] U_BASE     = U_BASE_DEFAULT,
    parameter logic [17:0] V_BASE     = V_BASE_DEFAULT,
    parameter logic [6:0]  S_RAM_BASE = S_RAM_BASE_DEFAULT
) (
    input  logic        CLOCK_50_I,
    input  logic        Resetn,
    input  logic        WS_start,
    output logic        WS_done,
    input  logic [4:0]  block_row,
    input  logic [5:0]  block_col,
    input  logic [1:0]  plane,
    output logic [6:0]  RAM_address_a,
    output logic [6:0]  RAM_address_b,
    input  logic [31:0] RAM_read_data_a,
    input  logic [31:0] RAM_read_data_b,
    output logic [17:0] SRAM_address,
    output logic [15:0] SRAM_write_data,
    output logic        SRAM_we_n
);

    ws_state_type state;
    ws_plane_type plane_q;
    logic         start_prev;
    logic [4:0]   rd_pair;
    logic [4:0]   wr_pair;
    logic [17:0]  row_addr;

    logic [17:0]  plane_base;
    logic [17:0]  start_addr;
    logic [17:0]  words_per_row;
    logic [17:0]  wr_addr;
    logic [17:0]  row_addr_next;
    logic [6:0]   rd_addr_a;
    logic [6:0]   rd_addr_b;
    logic [7:0]   pixel_a;
    logic [7:0]   pixel_b;

    ws_clip8 clip_a (.value(RAM_read_data_a), .pixel(pixel_a));
    ws_clip8 clip_b (.value(RAM_read_data_b), .pixel(pixel_b));

    // Read data arrives in the write cycle itself, so the word is formed combinationally.
    assign SRAM_write_data = SRAM_we_n ? 16'd0 : {pixel_a, pixel_b};

    always_comb begin
        plane_base = Y_BASE;
        case (plane)
            2'd1:    plane_base = U_BASE;
            2'd2:    plane_base = V_BASE;
            default: plane_base = Y_BASE;
        endcase
        start_addr = plane_base + block_row_offset(block_row, plane == PLANE_Y)
                   + {10'd0, block_col, 2'b00};

        words_per_row = (plane_q == PLANE_Y) ? Y_WORDS_PER_ROW : UV_WORDS_PER_ROW;
        wr_addr       = row_addr + {16'd0, wr_pair[1:0]};
        row_addr_next = (wr_pair[1:0] == 2'd3) ? row_addr + words_per_row : row_addr;
        rd_addr_a     = S_RAM_BASE + {1'b0, rd_pair, 1'b0};
        rd_addr_b     = S_RAM_BASE + {1'b0, rd_pair, 1'b1};
    end

    always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
        if (!Resetn) begin
            state         <= S_WS_IDLE;
            plane_q       <= PLANE_Y;
            start_prev    <= 1'b0;
            rd_pair       <= 5'd0;
            wr_pair       <= 5'd0;
            row_addr      <= 18'd0;
            RAM_address_a <= 7'd0;
            RAM_address_b <= 7'd0;
            SRAM_address  <= 18'd0;
            SRAM_we_n     <= 1'b1;
            WS_done       <= 1'b0;
        end else begin
            start_prev <= WS_start;
            case (state)
                S_WS_IDLE: begin
                    if (WS_start && !start_prev) begin
                        plane_q       <= ws_plane_type'(plane);
                        row_addr      <= start_addr;
                        RAM_address_a <= S_RAM_BASE;
                        RAM_address_b <= S_RAM_BASE + 7'd1;
                        rd_pair       <= 5'd1;
                        wr_pair       <= 5'd0;
                        state         <= S_WS_LEAD_IN;
                    end
                end
                S_WS_LEAD_IN: begin
                    if (plane_q == PLANE_INVALID) begin
                        WS_done <= 1'b1;
                        state   <= S_WS_DONE;
                    end else begin
                        SRAM_address  <= wr_addr;
                        SRAM_we_n     <= 1'b0;
                        row_addr      <= row_addr_next;
                        wr_pair       <= wr_pair + 5'd1;
                        RAM_address_a <= rd_addr_a;
                        RAM_address_b <= rd_addr_b;
                        rd_pair       <= rd_pair + 5'd1;
                        state         <= S_WS_COMMON;
                    end
                end
                S_WS_COMMON: begin
                    SRAM_address <= wr_addr;
                    SRAM_we_n    <= 1'b0;
                    row_addr     <= row_addr_next;
                    wr_pair      <= wr_pair + 5'd1;
                    // The last pair's read was issued a cycle earlier; only its write remains.
                    if (wr_pair == 5'd31) begin
                        state <= S_WS_LEAD_OUT;
                    end else begin
                        RAM_address_a <= rd_addr_a;
                        RAM_address_b <= rd_addr_b;
                        rd_pair       <= rd_pair + 5'd1;
                    end
                end
                S_WS_LEAD_OUT: begin
                    SRAM_we_n <= 1'b1;
                    WS_done   <= 1'b1;
                    state     <= S_WS_DONE;
                end
                S_WS_DONE: begin
                    WS_done <= 1'b0;
                    state   <= S_WS_IDLE;
                end
                default: state <= S_WS_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ws_writeback.sv
// Self-checking bench for ws_writeback: table-driven blocks plus held-start,
// mid-block reset and invalid-plane sequences, with a write scoreboard.
module tb_ws_writeback;

    logic        CLOCK_50_I = 1'b0;
    logic        Resetn     = 1'b1;
    logic        WS_start   = 1'b0;
    logic        WS_done;
    logic [4:0]  block_row  = 5'd0;
    logic [5:0]  block_col  = 6'd0;
    logic [1:0]  plane      = 2'd0;
    logic [6:0]  RAM_address_a;
    logic [6:0]  RAM_address_b;
    logic [31:0] RAM_read_data_a = 32'd0;
    logic [31:0] RAM_read_data_b = 32'd0;
    logic [17:0] SRAM_address;
    logic [15:0] SRAM_write_data;
    logic        SRAM_we_n;

`ifdef WS_CLIP_EN
    localparam logic [15:0] CLIP_WORD = 16'h00FF;
`else
    localparam logic [15:0] CLIP_WORD = 16'hFB2C;
`endif

    typedef struct {
        logic [17:0] addr;
        logic [15:0] data;
    } wr_item_t;

    typedef struct {
        logic [1:0]  pl;
        logic [4:0]  rb;
        logic [5:0]  cb;
        int          pat;
        bit          toggle;
        logic [17:0] exp_first_addr;
        logic [17:0] exp_last_addr;
        bit          chk_word;
        logic [15:0] exp_first_word;
    } vec_t;

    logic signed [31:0] s_mem [0:127];
    wr_item_t           exp_q [$];
    vec_t               vecs [6];

    int vectors_applied = 0;
    int miscompares     = 0;

    int          res_writes;
    int          res_first_cyc;
    int          res_last_cyc;
    int          res_done_cnt;
    int          res_done_cyc;
    logic [17:0] res_first_addr;
    logic [17:0] res_last_addr;
    logic [15:0] res_first_word;

    ws_writeback dut (
        .CLOCK_50_I      (CLOCK_50_I),
        .Resetn          (Resetn),
        .WS_start        (WS_start),
        .WS_done         (WS_done),
        .block_row       (block_row),
        .block_col       (block_col),
        .plane           (plane),
        .RAM_address_a   (RAM_address_a),
        .RAM_address_b   (RAM_address_b),
        .RAM_read_data_a (RAM_read_data_a),
        .RAM_read_data_b (RAM_read_data_b),
        .SRAM_address    (SRAM_address),
        .SRAM_write_data (SRAM_write_data),
        .SRAM_we_n       (SRAM_we_n)
    );

    always #5 CLOCK_50_I = ~CLOCK_50_I;

    // Dual-port RAM model: registered read, data valid the cycle after the address.
    always @(posedge CLOCK_50_I) begin
        RAM_read_data_a <= s_mem[RAM_address_a];
        RAM_read_data_b <= s_mem[RAM_address_b];
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors_applied++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, actual, actual, expected, expected);
        end
    endtask

    function automatic logic [7:0] pix(input logic signed [31:0] x);
`ifdef WS_CLIP_EN
        if (x < 0) return 8'd0;
        if (x > 255) return 8'd255;
        return x[7:0];
`else
        return x[7:0];
`endif
    endfunction

    task automatic fillPattern(input int pat);
        for (int i = 0; i < 128; i++) begin
            case (pat)
                0:       s_mem[i] = (i >= 64) ? 10 * ((i - 64) / 8) + ((i - 64) % 8) : 0;
                1:       s_mem[i] = 123;
                2:       s_mem[i] = $signed($urandom_range(0, 900)) - 300;
                default: s_mem[i] = 0;
            endcase
        end
        if (pat == 3) begin
            s_mem[64] = -5;
            s_mem[65] = 300;
        end
    endtask

    task automatic pushExpected(input logic [1:0] pl, input logic [4:0] rb, input logic [5:0] cb);
        int base;
        int w;
        int idx;
        base = (pl == 2'd0) ? 0 : (pl == 2'd1) ? 38400 : 57600;
        w    = (pl == 2'd0) ? 160 : 80;
        for (int k = 0; k < 32; k++) begin
            int r;
            int c;
            wr_item_t item;
            r   = k / 4;
            c   = k % 4;
            idx = 64 + 8 * r + 2 * c;
            item.addr = 18'(base + (8 * int'(rb) + r) * w + 4 * int'(cb) + c);
            item.data = {pix(s_mem[idx]), pix(s_mem[idx + 1])};
            exp_q.push_back(item);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] pl, input logic [4:0] rb, input logic [5:0] cb,
                                 input bit held, input bit toggle, input int reset_at);
        wr_item_t item;
        WS_start = 1'b0;
        @(posedge CLOCK_50_I); #1;
        plane     = pl;
        block_row = rb;
        block_col = cb;
        WS_start  = 1'b1;
        if (pl != 2'd3) pushExpected(pl, rb, cb);
        res_writes     = 0;
        res_first_cyc  = -1;
        res_last_cyc   = -1;
        res_done_cnt   = 0;
        res_done_cyc   = -1;
        res_first_addr = '0;
        res_last_addr  = '0;
        res_first_word = '0;
        for (int cyc = 0; cyc < 46; cyc++) begin
            if (cyc > 0) begin
                @(posedge CLOCK_50_I); #1;
            end
            if (cyc == 1) begin
                block_row = ~rb;
                block_col = ~cb;
                plane     = pl ^ 2'b01;
            end
            if (!held && !toggle && cyc == 3) WS_start = 1'b0;
            if (toggle && cyc == 10) WS_start = 1'b0;
            if (toggle && cyc == 11) WS_start = 1'b1;
            if (cyc == reset_at) begin
                Resetn = 1'b0;
                #1;
                checkOutput("reset_we_n_immediate", 32'(SRAM_we_n), 32'd1);
                checkOutput("reset_done_immediate", 32'(WS_done), 32'd0);
                checkOutput("reset_sram_addr_immediate", 32'(SRAM_address), 32'd0);
                exp_q.delete();
            end
            if (reset_at >= 0 && cyc == reset_at + 2) Resetn = 1'b1;
            @(negedge CLOCK_50_I);
            if (WS_done === 1'b1) begin
                res_done_cnt++;
                res_done_cyc = cyc;
            end
            if (SRAM_we_n !== 1'b1) begin
                res_writes++;
                if (res_first_cyc < 0) begin
                    res_first_cyc  = cyc;
                    res_first_addr = SRAM_address;
                    res_first_word = SRAM_write_data;
                end
                res_last_cyc  = cyc;
                res_last_addr = SRAM_address;
                checkOutput("write_was_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    item = exp_q.pop_front();
                    checkOutput("sram_addr", 32'(SRAM_address), 32'(item.addr));
                    checkOutput("sram_data", 32'(SRAM_write_data), 32'(item.data));
                end
            end
        end
        checkOutput("expected_writes_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        vecs[0] = '{pl:2'd0, rb:5'd0,  cb:6'd0,  pat:0, toggle:1'b0, exp_first_addr:18'd0,
                    exp_last_addr:18'd1123,  chk_word:1'b1, exp_first_word:16'h0001};
        vecs[1] = '{pl:2'd1, rb:5'd29, cb:6'd19, pat:1, toggle:1'b0, exp_first_addr:18'd57036,
                    exp_last_addr:18'd57599, chk_word:1'b1, exp_first_word:16'h7B7B};
        vecs[2] = '{pl:2'd2, rb:5'd5,  cb:6'd3,  pat:2, toggle:1'b1, exp_first_addr:18'd60812,
                    exp_last_addr:18'd61375, chk_word:1'b0, exp_first_word:16'h0000};
        vecs[3] = '{pl:2'd0, rb:5'd29, cb:6'd39, pat:0, toggle:1'b0, exp_first_addr:18'd37276,
                    exp_last_addr:18'd38399, chk_word:1'b1, exp_first_word:16'h0001};
        vecs[4] = '{pl:2'd0, rb:5'd0,  cb:6'd0,  pat:3, toggle:1'b0, exp_first_addr:18'd0,
                    exp_last_addr:18'd1123,  chk_word:1'b1, exp_first_word:CLIP_WORD};
        vecs[5] = '{pl:2'd0, rb:5'd31, cb:6'd63, pat:1, toggle:1'b0, exp_first_addr:18'd39932,
                    exp_last_addr:18'd41055, chk_word:1'b1, exp_first_word:16'h7B7B};

        fillPattern(0);
        #1 Resetn = 1'b0;
        #1;
        checkOutput("reset_we_n", 32'(SRAM_we_n), 32'd1);
        checkOutput("reset_done", 32'(WS_done), 32'd0);
        checkOutput("reset_sram_addr", 32'(SRAM_address), 32'd0);
        checkOutput("reset_sram_data", 32'(SRAM_write_data), 32'd0);
        checkOutput("reset_ram_addr_a", 32'(RAM_address_a), 32'd0);
        checkOutput("reset_ram_addr_b", 32'(RAM_address_b), 32'd0);
        repeat (3) @(posedge CLOCK_50_I);
        #1 Resetn = 1'b1;

        for (int v = 0; v < 6; v++) begin
            fillPattern(vecs[v].pat);
            applyStimulus(vecs[v].pl, vecs[v].rb, vecs[v].cb, 1'b0, vecs[v].toggle, -1);
            $display("[TB] vector %0d: %0d writes, first 0x%0h, last 0x%0h", v, res_writes, res_first_addr, res_last_addr);
            checkOutput("block_write_count", 32'(res_writes), 32'd32);
            checkOutput("first_write_cycle", 32'(res_first_cyc), 32'd2);
            checkOutput("last_write_cycle", 32'(res_last_cyc), 32'd33);
            checkOutput("done_pulse_count", 32'(res_done_cnt), 32'd1);
            checkOutput("done_cycle", 32'(res_done_cyc), 32'd34);
            checkOutput("first_sram_addr", 32'(res_first_addr), 32'(vecs[v].exp_first_addr));
            checkOutput("last_sram_addr", 32'(res_last_addr), 32'(vecs[v].exp_last_addr));
            if (vecs[v].chk_word)
                checkOutput("first_sram_word", 32'(res_first_word), 32'(vecs[v].exp_first_word));
        end

        fillPattern(2);
        applyStimulus(2'd1, 5'd3, 6'd7, 1'b1, 1'b0, -1);
        checkOutput("held_start_writes", 32'(res_writes), 32'd32);
        checkOutput("held_start_done_count", 32'(res_done_cnt), 32'd1);
        applyStimulus(2'd0, 5'd1, 6'd2, 1'b0, 1'b0, -1);
        checkOutput("retoggle_writes", 32'(res_writes), 32'd32);
        checkOutput("retoggle_done_cycle", 32'(res_done_cyc), 32'd34);

        fillPattern(0);
        applyStimulus(2'd0, 5'd2, 6'd5, 1'b0, 1'b0, 15);
        checkOutput("reset_mid_writes", 32'(res_writes), 32'd13);
        checkOutput("reset_mid_last_cycle", 32'(res_last_cyc), 32'd14);
        checkOutput("reset_mid_done_count", 32'(res_done_cnt), 32'd0);
        applyStimulus(2'd2, 5'd10, 6'd10, 1'b0, 1'b0, -1);
        checkOutput("after_reset_writes", 32'(res_writes), 32'd32);
        checkOutput("after_reset_done_cycle", 32'(res_done_cyc), 32'd34);

        applyStimulus(2'd3, 5'd4, 6'd4, 1'b0, 1'b0, -1);
        checkOutput("invalid_plane_writes", 32'(res_writes), 32'd0);
        checkOutput("invalid_plane_done_count", 32'(res_done_cnt), 32'd1);
        checkOutput("invalid_plane_done_cycle", 32'(res_done_cyc), 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
